// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: I/D cache read arbitration and D write pass-through onto one AXI3 master port
//
// Ports
//   aclk, aresetn                         clock, async active-low reset
//   i_ar* / i_r*                          I-cache read request and read data
//   d_ar* / d_r*                          D-cache read request and read data
//   d_aw* / d_w* / d_b*                   D-cache write address, data and response
//   ar* / r*                              AXI3 read address and read data channels
//   aw* / w* / b*                         AXI3 write address, data and response channels
//   ar/aw burst, lock, cache, prot        constant INCR, normal, non-cacheable, unprivileged
module axi_mem_arbiter #(
    parameter logic [3:0] I_ID       = 4'd0,
    parameter logic [3:0] D_ID       = 4'd1,
    parameter int         STARVE_MAX = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] i_araddr,
    input  logic [3:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [31:0] d_araddr,
    input  logic [3:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    input  logic [31:0] d_awaddr,
    input  logic [3:0]  d_awlen,
    input  logic [2:0]  d_awsize,
    input  logic        d_awvalid,
    output logic        d_awready,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_wlast,
    input  logic        d_wvalid,
    output logic        d_wready,
    output logic        d_bvalid,
    input  logic        d_bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

    rstate_t       rstate;
    wstate_t       wstate;
    logic          grant_d;
    logic [SW-1:0] starve_cnt;
    logic          wr_busy, starved, d_win, rd_i, rd_d, w_data, w_resp;
    logic          unused;

    assign unused = ^{rid, rresp, bid, bresp};

    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'h0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'h0;

    // A write counts as outstanding from the moment its address is offered until B completes,
    // so a D read can never overtake a write to the same location.
    assign wr_busy = (wstate != W_IDLE) | d_awvalid;
    assign starved = i_arvalid & (starve_cnt == SW'(STARVE_MAX));
    assign d_win   = d_arvalid & ~wr_busy & ~starved;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate     <= R_IDLE;
            grant_d    <= 1'b0;
            arvalid    <= 1'b0;
            arid       <= '0;
            araddr     <= '0;
            arlen      <= '0;
            arsize     <= '0;
            starve_cnt <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (d_win) begin
                        rstate  <= R_AR;
                        grant_d <= 1'b1;
                        arvalid <= 1'b1;
                        arid    <= D_ID;
                        araddr  <= d_araddr;
                        arlen   <= d_arlen;
                        arsize  <= d_arsize;
                        if (i_arvalid && starve_cnt != SW'(STARVE_MAX))
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (i_arvalid) begin
                        rstate     <= R_AR;
                        grant_d    <= 1'b0;
                        arvalid    <= 1'b1;
                        arid       <= I_ID;
                        araddr     <= i_araddr;
                        arlen      <= i_arlen;
                        arsize     <= 3'b010;
                        starve_cnt <= '0;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready && rlast)
                        rstate <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign rd_i      = (rstate == R_DATA) & ~grant_d;
    assign rd_d      = (rstate == R_DATA) & grant_d;
    assign i_arready = (rstate == R_AR) & ~grant_d & arready;
    assign d_arready = (rstate == R_AR) & grant_d & arready;
    assign i_rvalid  = rd_i & rvalid;
    assign i_rlast   = rd_i & rlast;
    assign i_rdata   = rd_i ? rdata : '0;
    assign d_rvalid  = rd_d & rvalid;
    assign d_rlast   = rd_d & rlast;
    assign d_rdata   = rd_d ? rdata : '0;
    assign rready    = (rd_i & i_rready) | (rd_d & d_rready);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate  <= W_IDLE;
            awvalid <= 1'b0;
            awid    <= '0;
            awaddr  <= '0;
            awlen   <= '0;
            awsize  <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (d_awvalid) begin
                        wstate  <= W_AW;
                        awvalid <= 1'b1;
                        awid    <= D_ID;
                        awaddr  <= d_awaddr;
                        awlen   <= d_awlen;
                        awsize  <= d_awsize;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready && wlast)
                        wstate <= W_RESP;
                end
                W_RESP: begin
                    if (bvalid && bready)
                        wstate <= W_IDLE;
                end
            endcase
        end
    end

    assign w_data    = (wstate == W_DATA);
    assign w_resp    = (wstate == W_RESP);
    assign d_awready = (wstate == W_AW) & awready;
    assign wvalid    = w_data & d_wvalid;
    assign d_wready  = w_data & wready;
    assign wdata     = w_data ? d_wdata : '0;
    assign wstrb     = w_data ? d_wstrb : '0;
    assign wlast     = w_data & d_wlast;
    assign wid       = w_data ? D_ID : '0;
    assign d_bvalid  = w_resp & bvalid;
    assign bready    = w_resp & d_bready;
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: scoreboard bench for axi_mem_arbiter with an AXI3 slave model
module tb_axi_mem_arbiter;
    localparam logic [3:0] I_ID = 4'd0;
    localparam logic [3:0] D_ID = 4'd1;

    logic aclk = 0, aresetn = 0;
    logic [31:0] i_araddr, i_rdata, d_araddr, d_rdata, d_awaddr, d_wdata;
    logic [3:0]  i_arlen, d_arlen, d_awlen, d_wstrb;
    logic [2:0]  d_arsize, d_awsize;
    logic i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
    logic d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
    logic d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    logic [32:0] i_exp[$], d_exp[$];
    logic [42:0] ar_exp[$], aw_exp[$];
    logic [36:0] w_exp[$];
    int errors = 0, checks = 0;
    int cyc = 0, i_beats = 0, d_rlast_cyc = 0, arv_rise_cyc = 0, b_hs_cyc = 0, b_delay = 1;
    logic wr_pending = 0, arv_prev = 0;
    logic [32:0] me;

    axi_mem_arbiter #(.I_ID(I_ID), .D_ID(D_ID), .STARVE_MAX(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid), .d_awready(d_awready),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid), .d_wready(d_wready),
        .d_bvalid(d_bvalid), .d_bready(d_bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dpat(input logic [31:0] a, input logic [3:0] b);
        return (a + {26'd0, b, 2'b00}) ^ 32'h5A5A_0000;
    endfunction

    // read data monitor: pops the per-master scoreboards
    always @(negedge aclk) begin
        if (aresetn) begin
            if (i_rvalid && i_rready) begin
                i_beats++;
                if (i_exp.size() == 0) check("i_r_unexp", 1, 0);
                else begin
                    me = i_exp.pop_front();
                    check("i_r", {31'd0, i_rlast, i_rdata}, {31'd0, me});
                end
            end
            if (d_rvalid && d_rready) begin
                if (d_exp.size() == 0) check("d_r_unexp", 1, 0);
                else begin
                    me = d_exp.pop_front();
                    check("d_r", {31'd0, d_rlast, d_rdata}, {31'd0, me});
                end
                if (d_rlast) d_rlast_cyc = cyc;
            end
            if (wr_pending && arvalid) check("raw_order", {60'd0, arid}, {60'd0, I_ID});
            if (arvalid && !arv_prev) arv_rise_cyc = cyc;
        end
        arv_prev = arvalid;
    end

    // AXI3 slave: one read at a time, random R gaps, programmable B delay
    initial begin : slave
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs, r_busy, wl;
        logic [31:0] r_addr;
        logic [3:0] r_len, r_beat, r_id;
        int ws, bcnt;
        arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        r_busy = 0; r_addr = 0; r_len = 0; r_beat = 0; r_id = 0; ws = 0; bcnt = 0; wl = 0;
        forever begin
            @(negedge aclk);
            ar_hs = arvalid & arready;
            r_hs  = rvalid & rready;
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            b_hs  = bvalid & bready;
            wl    = wlast;
            if (ar_hs) begin
                if (ar_exp.size() == 0) check("ar_unexp", 1, 0);
                else check("ar", {21'd0, arid, araddr, arlen, arsize}, {21'd0, ar_exp.pop_front()});
                r_id = arid; r_addr = araddr; r_len = arlen;
            end
            if (aw_hs) begin
                if (aw_exp.size() == 0) check("aw_unexp", 1, 0);
                else check("aw", {21'd0, awid, awaddr, awlen, awsize}, {21'd0, aw_exp.pop_front()});
            end
            if (w_hs) begin
                if (w_exp.size() == 0) check("w_unexp", 1, 0);
                else check("w", {23'd0, wid, wlast, wstrb, wdata}, {23'd0, D_ID, w_exp.pop_front()});
            end
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                arready = 1; rvalid = 0; rlast = 0; r_busy = 0;
                awready = 1; wready = 0; bvalid = 0; ws = 0;
            end else begin
                if (ar_hs) begin
                    arready = 0; r_busy = 1; r_beat = 0; rvalid = 1;
                end else if (r_hs && rlast) begin
                    r_busy = 0; rvalid = 0; arready = 1;
                end else if (r_hs) begin
                    r_beat++;
                    rvalid = $urandom_range(0, 3) != 0;
                end else if (r_busy) rvalid = 1;
                rid = r_id; rdata = dpat(r_addr, r_beat); rlast = r_beat == r_len;
                if (ws == 0) begin
                    if (aw_hs) begin awready = 0; wready = 1; ws = 1; end
                end else if (ws == 1) begin
                    if (w_hs && wl) begin wready = 0; bcnt = b_delay; ws = 2; end
                    else if (w_hs) wready = $urandom_range(0, 3) != 0;
                    else wready = 1;
                end else if (ws == 2) begin
                    if (bcnt == 0) begin bvalid = 1; ws = 3; end
                    else bcnt--;
                end else if (b_hs) begin
                    bvalid = 0; awready = 1; ws = 0;
                end
            end
        end
    end

    task automatic i_req(input logic [31:0] a, input logic [3:0] l);
        int n;
        for (int b = 0; b <= int'(l); b++) i_exp.push_back({b == int'(l), dpat(a, 4'(b))});
        i_araddr = a; i_arlen = l; i_arvalid = 1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!i_arready && n < 300);
        check("i_ar_wait", {63'd0, n < 300}, 1);
        @(posedge aclk);
        #1 i_arvalid = 0;
    endtask

    task automatic d_req(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
        int n;
        for (int b = 0; b <= int'(l); b++) d_exp.push_back({b == int'(l), dpat(a, 4'(b))});
        d_araddr = a; d_arlen = l; d_arsize = s; d_arvalid = 1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!d_arready && n < 300);
        check("d_ar_wait", {63'd0, n < 300}, 1);
        @(posedge aclk);
        #1 d_arvalid = 0;
    endtask

    task automatic d_write(input logic [31:0] a, input logic [3:0] l);
        int n;
        aw_exp.push_back({D_ID, a, l, 3'b010});
        d_awaddr = a; d_awlen = l; d_awsize = 3'b010; d_awvalid = 1; wr_pending = 1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!d_awready && n < 100);
        check("d_aw_wait", {63'd0, n < 100}, 1);
        @(posedge aclk);
        #1 d_awvalid = 0;
        for (int b = 0; b <= int'(l); b++) begin
            d_wdata = $urandom; d_wstrb = 4'($urandom); d_wlast = b == int'(l); d_wvalid = 1;
            w_exp.push_back({d_wlast, d_wstrb, d_wdata});
            n = 0;
            do begin @(negedge aclk); n++; end while (!d_wready && n < 100);
            check("d_w_wait", {63'd0, n < 100}, 1);
            @(posedge aclk);
            #1 d_wvalid = 0;
        end
        d_bready = 1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!d_bvalid && n < 100);
        check("d_b_wait", {63'd0, n < 100}, 1);
        b_hs_cyc = cyc;
        @(posedge aclk);
        #1 d_bready = 0; wr_pending = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((i_exp.size() != 0 || d_exp.size() != 0) && n < 500) begin @(negedge aclk); n++; end
        check("drain", {63'd0, n < 500}, 1);
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, n;
        i_araddr = 0; i_arlen = 0; i_arvalid = 0; i_rready = 1;
        d_araddr = 0; d_arlen = 0; d_arsize = 0; d_arvalid = 0; d_rready = 1;
        d_awaddr = 0; d_awlen = 0; d_awsize = 0; d_awvalid = 0;
        d_wdata = 0; d_wstrb = 0; d_wlast = 0; d_wvalid = 0; d_bready = 0;
        #22;
        check("rst_rd", {58'd0, arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid}, 0);
        check("rst_wr", {58'd0, awvalid, wvalid, bready, d_awready, d_wready, d_bvalid}, 0);
        check("rst_ar", {21'd0, arid, araddr, arlen, arsize}, 0);
        check("rst_aw", {21'd0, awid, awaddr, awlen, awsize}, 0);
        check("consts", {42'd0, arburst, arlock, arcache, arprot, awburst, awlock, awcache, awprot},
              {42'd0, 2'b01, 2'b00, 4'h0, 3'h0, 2'b01, 2'b00, 4'h0, 3'h0});
        @(negedge aclk) aresetn = 1;
        repeat (2) @(posedge aclk);
        #1;

        // I read alone
        ar_exp.push_back({I_ID, 32'h1FC0_0000, 4'd7, 3'b010});
        i_req(32'h1FC0_0000, 4'd7);
        drain();

        // simultaneous I and D: D first, I one idle cycle after D's last beat
        ar_exp.push_back({D_ID, 32'h8000_1000, 4'd0, 3'b011});
        ar_exp.push_back({I_ID, 32'h1FC0_0040, 4'd3, 3'b010});
        fork
            d_req(32'h8000_1000, 4'd0, 3'b011);
            i_req(32'h1FC0_0040, 4'd3);
        join
        check("i_after_d", 64'(arv_rise_cyc - d_rlast_cyc), 2);
        drain();

        // starvation: I wins after exactly 8 D grants
        for (int k = 0; k < 8; k++) ar_exp.push_back({D_ID, 32'h8001_0000 + 32'(k * 64), 4'd0, 3'b010});
        ar_exp.push_back({I_ID, 32'h1FC0_0400, 4'd3, 3'b010});
        ar_exp.push_back({D_ID, 32'h8001_0200, 4'd0, 3'b010});
        fork
            for (int k = 0; k < 9; k++) d_req(32'h8001_0000 + 32'(k * 64), 4'd0, 3'b010);
            begin
                i_req(32'h1FC0_0400, 4'd3);
                check("starve_clr", {60'd0, dut.starve_cnt}, 0);
            end
        join
        drain();

        // D read held off by an unacknowledged D write
        b_delay = 5;
        ar_exp.push_back({D_ID, 32'h8000_3000, 4'd1, 3'b010});
        fork
            d_write(32'h8000_3000, 4'd3);
            begin
                repeat (2) @(posedge aclk);
                #1 d_req(32'h8000_3000, 4'd1, 3'b010);
            end
        join
        check("raw_ar_lat", 64'(arv_rise_cyc - b_hs_cyc), 2);
        drain();
        b_delay = 1;

        // I read overlapping a D write
        ar_exp.push_back({I_ID, 32'h1FC0_0200, 4'd7, 3'b010});
        fork
            i_req(32'h1FC0_0200, 4'd7);
            d_write(32'h8000_2000, 4'd3);
        join
        drain();

        // reset mid-burst, then a fresh read
        ar_exp.push_back({I_ID, 32'h1FC0_0100, 4'd7, 3'b010});
        base = i_beats;
        i_req(32'h1FC0_0100, 4'd7);
        n = 0;
        while (i_beats < base + 2 && n < 200) begin @(negedge aclk); #1; n++; end
        check("rst_beat_wait", {63'd0, n < 200}, 1);
        #1 aresetn = 0;
        #1;
        check("midrst", {61'd0, arvalid, rready, i_rvalid}, 0);
        i_exp.delete();
        ar_exp.delete();
        repeat (3) @(posedge aclk);
        @(negedge aclk) aresetn = 1;
        repeat (2) @(posedge aclk);
        #1;
        ar_exp.push_back({I_ID, 32'h1FC0_0800, 4'd7, 3'b010});
        base = i_beats;
        i_req(32'h1FC0_0800, 4'd7);
        drain();
        check("post_rst_beats", 64'(i_beats - base), 8);

        check("ar_left", 64'(ar_exp.size()), 0);
        check("aw_left", 64'(aw_exp.size()), 0);
        check("w_left", 64'(w_exp.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
